// File: rtl/exc_ctrl.sv
// Exception/interrupt control stage feeding CP0: prioritises MEM-stage exception
// flags and synchronised interrupts, then issues one registered commit with flush and redirect.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_hw_i,
  output logic [5:0]  int_sync_o,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] mem_addr_i,
  input  logic [8:0]  mem_exc_i,
  input  logic        mem_busy_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] exc_pc_o,
  output logic        exc_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_o
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT, DRAIN} state_t;

  state_t          state_reg;
  logic [CW-1:0]   drain_cnt_reg;
  logic [5:0]      sync1_reg;

  logic [31:0] status_fwd;
  logic [7:0]  cause_ip;
  logic [31:0] epc_fwd;
  logic        int_pend;
  logic        sel;
  logic [4:0]  code;
  logic [31:0] bad;
  logic        unused_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg  <= '0;
      int_sync_o <= '0;
    end else begin
      sync1_reg  <= int_hw_i;
      int_sync_o <= sync1_reg;
    end
  end

  // Forward a CP0 write still in WB so a just-written EXL/IE/IM/EPC is honoured.
  always_comb begin
    status_fwd = cp0_status_i;
    cause_ip   = cp0_cause_i[15:8];
    epc_fwd    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      if (wb_cp0_waddr_i == 5'd12) status_fwd    = wb_cp0_wdata_i;
      if (wb_cp0_waddr_i == 5'd13) cause_ip[1:0] = wb_cp0_wdata_i[9:8];
      if (wb_cp0_waddr_i == 5'd14) epc_fwd       = wb_cp0_wdata_i;
    end
  end

  assign int_pend    = status_fwd[0] & ~status_fwd[1] & (|(cause_ip & status_fwd[15:8]));
  assign unused_bits = ^{status_fwd[31:16], status_fwd[7:2], cp0_cause_i[31:16], cp0_cause_i[7:0]};

  // Nothing is taken in COMMIT/DRAIN, so a stale EXL cannot trigger a second take.
  always_comb begin
    sel  = 1'b0;
    code = 5'h00;
    bad  = 32'h0;
    if (mem_valid_i && (state_reg == IDLE || state_reg == WAIT)) begin
      sel = 1'b1;
      if (int_pend)           code = 5'h01;
      else if (mem_exc_i[0]) begin code = 5'h04; bad = mem_pc_i; end
      else if (mem_exc_i[1])  code = 5'h0a;
      else if (mem_exc_i[2])  code = 5'h0c;
      else if (mem_exc_i[3])  code = 5'h0d;
      else if (mem_exc_i[4])  code = 5'h08;
      else if (mem_exc_i[5])  code = 5'h09;
      else if (mem_exc_i[6]) begin code = 5'h04; bad = mem_addr_i; end
      else if (mem_exc_i[7]) begin code = 5'h05; bad = mem_addr_i; end
      else if (mem_exc_i[8])  code = 5'h0e;
      else                    sel  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      drain_cnt_reg      <= '0;
      excepttype_o       <= '0;
      exc_pc_o           <= '0;
      exc_in_delayslot_o <= 1'b0;
      bad_addr_o         <= '0;
      flush_o            <= 1'b0;
      new_pc_o           <= '0;
      stall_o            <= 1'b0;
    end else begin
      flush_o      <= 1'b0;
      excepttype_o <= '0;
      new_pc_o     <= '0;
      stall_o      <= 1'b0;
      case (state_reg)
        IDLE, WAIT: begin
          if (!sel) begin
            state_reg <= IDLE;
          end else if (mem_busy_i) begin
            state_reg <= WAIT;
            stall_o   <= 1'b1;
          end else begin
            state_reg          <= COMMIT;
            flush_o            <= 1'b1;
            excepttype_o       <= {27'h0, code};
            exc_pc_o           <= mem_pc_i;
            exc_in_delayslot_o <= mem_in_delayslot_i;
            bad_addr_o         <= bad;
            new_pc_o           <= (code == 5'h0e) ? epc_fwd : EXC_VECTOR;
          end
        end
        COMMIT: begin
          state_reg     <= DRAIN;
          drain_cnt_reg <= '0;
        end
        DRAIN: begin
          if (drain_cnt_reg == DRAIN_LAST) begin
            state_reg     <= IDLE;
            drain_cnt_reg <= '0;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
